// File: rtl/match_window_monitor_pkg.sv
// Shared types and helpers for the match window monitor.
package match_window_monitor_pkg;

    typedef enum logic {IDLE, RUN} mwm_state_t;

    // Increment by one unless already at max_val; never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic inc,
                                            input logic [31:0] max_val);
        return (inc && (a != max_val)) ? a + 32'd1 : a;
    endfunction

endpackage

// File: rtl/match_window_monitor.sv
// Counts detector match pulses over fixed windows and reports each window's count
// on a valid/ready port, with a one-cycle alarm when the count reaches THRESH.
module match_window_monitor
    import match_window_monitor_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned WINDOW_LEN = 1000,
    parameter int unsigned THRESH     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             match_in,
    input  logic             report_ready,
    output logic             report_valid,
    output logic [CNT_W-1:0] report_count,
    output logic             report_overrun,
    output logic             alarm
);

    localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);

    mwm_state_t       state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             window_end;
    logic             crossing;

    always_comb begin
        next_cnt   = CNT_W'(sat_add(32'(match_cnt), match_in, CntMax));
        window_end = (win_cnt == WIN_W'(WINDOW_LEN - 1));
        // A saturated counter does not move, so it cannot re-cross the threshold.
        crossing   = (THRESH != 0) && (32'(next_cnt) == THRESH) && (next_cnt != match_cnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            win_cnt        <= '0;
            match_cnt      <= '0;
            report_valid   <= 1'b0;
            report_count   <= '0;
            report_overrun <= 1'b0;
            alarm          <= 1'b0;
        end else begin
            alarm <= 1'b0;
            // A window end in the same cycle overrides this below.
            if (report_valid && report_ready) begin
                report_valid   <= 1'b0;
                report_overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    win_cnt   <= '0;
                    match_cnt <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        win_cnt   <= '0;
                        match_cnt <= '0;
                    end else begin
                        alarm <= crossing;
                        if (window_end) begin
                            report_count   <= next_cnt;
                            report_valid   <= 1'b1;
                            report_overrun <= report_valid && !report_ready;
                            win_cnt        <= '0;
                            match_cnt      <= '0;
                        end else begin
                            win_cnt   <= win_cnt + WIN_W'(1);
                            match_cnt <= next_cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_window_monitor.sv
// Directed bench for match_window_monitor: one instance with an alarm threshold,
// one narrow-counter instance for saturation and disabled alarm.
module tb_match_window_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable_a;
    logic       enable_s;
    logic       match_in;
    logic       report_ready;

    logic       valid_a, overrun_a, alarm_a;
    logic [7:0] count_a;
    logic       valid_s, overrun_s, alarm_s;
    logic [1:0] count_s;

    int n_checks = 0;
    int n_pass   = 0;
    logic any_alarm_s;

    always #5 clk = ~clk;

    match_window_monitor #(
        .CNT_W(8), .WIN_W(4), .WINDOW_LEN(8), .THRESH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .match_in(match_in),
        .report_ready(report_ready), .report_valid(valid_a), .report_count(count_a),
        .report_overrun(overrun_a), .alarm(alarm_a)
    );

    match_window_monitor #(
        .CNT_W(2), .WIN_W(4), .WINDOW_LEN(8), .THRESH(0)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable_s), .match_in(match_in),
        .report_ready(report_ready), .report_valid(valid_s), .report_count(count_s),
        .report_overrun(overrun_s), .alarm(alarm_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (alarm_s) any_alarm_s = 1'b1;
    endtask

    // Sample bit i of bits as match_in on the i-th of n consecutive edges.
    task automatic run_samples(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            match_in = bits[i];
            step();
        end
        match_in = 1'b0;
    endtask

    // Run one full window; alarm expected only right after sample alarm_at (0 = never).
    task automatic alarm_window(input logic [7:0] bits, input int alarm_at, input string tag);
        for (int i = 1; i <= 8; i++) begin
            match_in = bits[i-1];
            step();
            check(tag, alarm_a, (i == alarm_at) ? 1 : 0);
        end
        match_in = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        enable_a     = 1'b0;
        enable_s     = 1'b0;
        match_in     = 1'b0;
        report_ready = 1'b1;
        any_alarm_s  = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        // Mid-window reset with two matches counted (alarm is high at this point).
        enable_a = 1'b1;
        step();
        run_samples(8'b0000_0011, 2);
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_overrun", overrun_a, 0);
        check("rst_alarm", alarm_a, 0);
        step();
        reset_n  = 1'b1;
        enable_a = 1'b0;
        run_samples(8'hff, 8);
        run_samples(8'hff, 4);
        check("idle_valid", valid_a, 0);
        check("idle_alarm", alarm_a, 0);

        // W1: three matches, ready held high.
        enable_a = 1'b1;
        step();
        run_samples(8'b0001_0101, 8);
        check("w1_valid", valid_a, 1);
        check("w1_count", count_a, 3);
        check("w1_overrun", overrun_a, 0);
        // W2: matches on samples 1 and 8.
        run_samples(8'b0000_0001, 1);
        check("w2_valid_one_cycle", valid_a, 0);
        run_samples(8'b0100_0000, 7);
        check("w2_valid", valid_a, 1);
        check("w2_last_cycle_count", count_a, 2);
        // W3: no matches.
        run_samples(8'b0000_0000, 8);
        check("w3_valid", valid_a, 1);
        check("w3_count", count_a, 0);

        // W4/W5: ready low across two window ends.
        report_ready = 1'b0;
        run_samples(8'b0000_0001, 8);
        check("w4_count", count_a, 1);
        check("w4_overrun", overrun_a, 1);
        run_samples(8'b0000_0000, 1);
        check("w5_stable_count", count_a, 1);
        check("w5_stable_valid", valid_a, 1);
        run_samples(8'b0001_1110, 7);
        check("w5_count", count_a, 4);
        check("w5_overrun", overrun_a, 1);
        check("w5_valid", valid_a, 1);

        // W6: one ready cycle consumes; matches on samples 2, 5, 6.
        report_ready = 1'b1;
        run_samples(8'b0000_0000, 1);
        check("w6_consume_valid", valid_a, 0);
        check("w6_consume_overrun", overrun_a, 0);
        for (int i = 2; i <= 8; i++) begin
            match_in = (i == 2 || i == 5 || i == 6);
            step();
            check("w6_alarm", alarm_a, (i == 5) ? 1 : 0);
        end
        match_in = 1'b0;
        check("w6_count", count_a, 3);
        // W7: second match on sample 4 re-arms in the new window.
        alarm_window(8'b0000_1001, 4, "w7_alarm");
        check("w7_count", count_a, 2);
        // W8: crossing on the window-end sample.
        alarm_window(8'b1000_0001, 8, "w8_alarm");
        check("w8_count", count_a, 2);

        // Drop enable mid-window with a report pending.
        report_ready = 1'b0;
        run_samples(8'b0000_0111, 3);
        enable_a = 1'b0;
        step();
        run_samples(8'b0000_0000, 8);
        run_samples(8'b0000_0000, 4);
        check("drop_valid", valid_a, 1);
        check("drop_count", count_a, 2);
        check("drop_overrun", overrun_a, 0);

        // Narrow counter: five matches saturate at 3, alarm disabled.
        report_ready = 1'b1;
        any_alarm_s  = 1'b0;
        enable_s     = 1'b1;
        step();
        run_samples(8'b0001_1111, 8);
        check("sat_valid", valid_s, 1);
        check("sat_count", count_s, 3);
        check("sat_overrun", overrun_s, 0);
        check("sat_no_alarm", any_alarm_s, 0);
        run_samples(8'b0000_0011, 2);
        enable_s = 1'b0;
        step();
        run_samples(8'b0000_0000, 8);
        run_samples(8'b0000_0000, 4);
        check("sat_drop_no_report", valid_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/match_window_monitor.md
# match_window_monitor

Downstream consumer of the 1001 sequence detector's single-cycle match output. It counts match pulses over fixed windows of `WINDOW_LEN` clock cycles and presents each window's count on a valid/ready report port. It also raises a one-cycle alarm when the in-window count reaches a threshold. It sits between the detector and the host/status logic.

## Interface
- `CNT_W`, default 8: match counter width; count saturates at 2^CNT_W−1.
- `WIN_W`, default 16: window counter width; must satisfy WINDOW_LEN ≤ 2^WIN_W.
- `WINDOW_LEN`, default 1000: window length in clock cycles, ≥ 2.
- `THRESH`, default 4: alarm threshold; 0 disables alarm.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run windows while high.
- `match_in` in 1: detector match output; each high cycle is one match.
- `report_ready` in 1: consumer accepts report.
- `report_valid` out 1: report holds a completed window count.
- `report_count` out CNT_W: matches in the reported window.
- `report_overrun` out 1: an unconsumed report was overwritten.
- `alarm` out 1: one-cycle pulse on threshold crossing.

## Operation
- FSM states: IDLE, RUN.
  - IDLE: counters cleared; `match_in` ignored. `enable`=1 sampled → RUN with win_cnt=0, match_cnt=0.
  - RUN: `enable`=0 sampled → IDLE. The partial window is discarded with no report; a pending report is kept.
- In RUN, every posedge samples `match_in`. match_cnt += match_in, saturating.
- win_cnt counts 0..WINDOW_LEN−1. At the posedge where win_cnt==WINDOW_LEN−1 (window end):
  - `report_count` ← sat(match_cnt + match_in), so a match on the last cycle counts in this window.
  - `report_valid` ← 1.
  - win_cnt and match_cnt ← 0.
- Handshake: the transfer happens at a posedge with `report_valid`&&`report_ready`. `report_valid`, `report_count` and `report_overrun` are stable while valid && !ready.
  - Transfer with no window end: valid ← 0, overrun ← 0.
  - Window end with valid && !ready: the new count overwrites, valid stays 1, overrun ← 1.
  - Window end with valid && ready: the old report is consumed, the new one loads, overrun ← 0.
- Alarm: registered. High for exactly the cycle after the posedge where the in-window count moves from THRESH−1 to THRESH, so at most once per window. The window-end match also qualifies.
- Saturation: match_cnt holds at max. No wrap. No alarm re-trigger.
- Reset (any time, including mid-window): state IDLE; all counters 0. `report_valid`, `report_count`, `report_overrun` and `alarm` are all 0.

## Timing
- Enable latency: `enable`=1 sampled at edge E0 → first window sample at E1. Window end at E_WINDOW_LEN.
- Report latency: `report_valid` rises in the cycle immediately after the window-end edge. This is a 1-cycle lag from the last sampled match.
- Back-to-back windows have no gap cycle. The next window's first sample is the edge after the window end.
- With `report_ready` held at 1, `report_valid` is high for exactly one cycle per window.
- Alarm latency: 1 cycle after the crossing match is sampled.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state enum `mwm_state_t` {IDLE, RUN}.
  - saturating-add helper function.
- Single module. The saturating counter is an inline function, not a sub-module.
- Optional reusable sub-module `sat_counter` (CNT_W-parameterised, inc/clear inputs) if the team already instantiates one elsewhere.

## Test plan
- Reset: assert `reset_n`=0 mid-window with 2 matches counted → all outputs 0 immediately. After release, still IDLE until `enable`.
- WINDOW_LEN=8, THRESH=0, ready=1: 3 matches in the window → `report_count`=3, valid high one cycle, starting the cycle after the 8th sample.
- Last-cycle match, WINDOW_LEN=8: matches only on samples 1 and 8 → `report_count`=2. The next window reports 0 if idle.
- Overrun: ready=0 across two window ends (counts 1 then 4) → `report_count`=4, overrun=1. Raise ready for one cycle → valid=0, overrun=0.
- Alarm, THRESH=2: matches on samples 2, 5, 6 → single alarm pulse the cycle after sample 5. The next window's second match pulses again.
- Saturation/enable: CNT_W=2 with 5 matches → `report_count`=3. Dropping `enable` mid-window → IDLE, no report, pending report unchanged.
